// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues in-order imem word requests and buffers {pc,instr} for decode
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic [31:0] pc, resp_pc, target;
  logic [CW-1:0] outstanding, drop, count;
  logic [CW:0] in_use;
  logic [PW-1:0] head, tail;
  logic [31:0] fifo_pc [FIFO_DEPTH];
  logic [31:0] fifo_instr [FIFO_DEPTH];
  logic req_fire, rsp_fire, push, pop;
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction
  always_comb begin
    in_use = {1'b0, count} + {1'b0, outstanding};
    imem_req_valid = rst_n && !redirect_valid && (in_use < (CW + 1)'(FIFO_DEPTH));
    imem_req_addr = pc;
    req_fire = imem_req_valid && imem_req_ready;
    rsp_fire = imem_rsp_valid && outstanding != '0;
    push = rsp_fire && drop == '0 && !redirect_valid;
    id_valid = count != '0;
    pop = id_valid && id_ready;
    id_pc = id_valid ? fifo_pc[head] : 32'h0;
    id_instr = id_valid ? fifo_instr[head] : NOP;
    target = redirect_pc & ~32'h3;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC;
      resp_pc <= RESET_PC;
      outstanding <= '0;
      drop <= '0;
      count <= '0;
      head <= '0;
      tail <= '0;
    end else if (redirect_valid) begin
      pc <= target;
      resp_pc <= target;
      outstanding <= outstanding - CW'(rsp_fire);
      drop <= outstanding - CW'(rsp_fire);
      count <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      if (req_fire) pc <= pc + 32'd4;
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_fire);
      if (rsp_fire && drop != '0) drop <= drop - CW'(1);
      if (push) resp_pc <= resp_pc + 32'd4;
      if (push) tail <= wrap_inc(tail);
      if (pop) head <= wrap_inc(head);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[tail] <= resp_pc;
      fifo_instr[tail] <= imem_rsp_data;
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n) assert (!(imem_rsp_valid && outstanding == '0)) else $warning("fetch_unit: response with no outstanding request ignored");
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against a small in-order instruction memory model
module tb_fetch_unit;
  logic clk, rst_n;
  logic imem_req_valid, imem_req_ready, imem_rsp_valid, redirect_valid;
  logic id_valid, id_ready;
  logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc, id_instr, id_pc;
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mq[$];
  logic [31:0] reqs[$];
  int req_cyc[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_in[$];
  int cycle = 0, last_due = 0, lat = 1, total = 0, passed = 0, failed = 0;
  bit rand_ready = 0, rand_lat = 0;
  fetch_unit #(.RESET_PC(32'h100), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
    if (imem_req_valid && imem_req_ready) begin
      int l = rand_lat ? int'($urandom_range(1, 3)) : lat;
      last_due = (cycle + l > last_due) ? cycle + l : last_due;
      mq.push_back('{imem_req_addr, last_due});
      reqs.push_back(imem_req_addr);
      req_cyc.push_back(cycle);
    end
    if (id_valid && id_ready) begin
      got_pc.push_back(id_pc);
      got_in.push_back(id_instr);
    end
    @(posedge clk);
    #1;
    cycle++;
    imem_rsp_valid = 0;
    imem_rsp_data = 0;
    if (mq.size() != 0 && mq[0].due <= cycle) begin
      imem_rsp_valid = 1;
      imem_rsp_data = word(mq[0].addr);
      void'(mq.pop_front());
    end
    if (rand_ready) imem_req_ready = 1'($urandom_range(0, 1));
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask
  task automatic hold_reset(input int l);
    rst_n = 0;
    redirect_valid = 0;
    redirect_pc = 0;
    imem_rsp_valid = 0;
    imem_rsp_data = 0;
    imem_req_ready = 1;
    rand_ready = 0;
    rand_lat = 0;
    lat = l;
    mq.delete();
    reqs.delete();
    req_cyc.delete();
    got_pc.delete();
    got_in.delete();
    repeat (2) @(posedge clk);
    #1;
    last_due = cycle;
  endtask
  task automatic chk_stream(input string tag, input logic [31:0] start, input int n);
    logic [31:0] p, d, e;
    for (int i = 0; i < n; i++) begin
      p = 32'hx;
      d = 32'hx;
      if (got_pc.size() != 0) begin
        p = got_pc.pop_front();
        d = got_in.pop_front();
      end
      e = start + 32'(4 * i);
      chk($sformatf("%s pc[%0d]", tag, i), p, e);
      chk($sformatf("%s instr[%0d]", tag, i), d, word(e));
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int n;
    id_ready = 1;
    hold_reset(1);
    chk("rst req_valid", 32'(imem_req_valid), 0);
    chk("rst id_valid", 32'(id_valid), 0);
    chk("rst id_instr", id_instr, 32'h13);
    chk("rst id_pc", id_pc, 0);
    rst_n = 1;
    #2;
    chk("t1 first addr", imem_req_addr, 32'h100);
    chk("t1 id_instr nop", id_instr, 32'h13);
    cyc();
    #2;
    chk("t1 still empty", 32'(id_valid), 0);
    run(8);
    chk("t1 nreq", 32'(reqs.size() >= 3), 1);
    chk("t1 req0", reqs.size() > 0 ? reqs[0] : 32'hx, 32'h100);
    chk("t1 req1", reqs.size() > 1 ? reqs[1] : 32'hx, 32'h104);
    chk("t1 req2", reqs.size() > 2 ? reqs[2] : 32'hx, 32'h108);
    chk("t1 back2back", req_cyc.size() > 1 ? 32'(req_cyc[1] - req_cyc[0]) : 32'hx, 1);
    chk_stream("t1", 32'h100, 3);
    id_ready = 0;
    hold_reset(1);
    rst_n = 1;
    run(10);
    #2;
    chk("t2 accepted", 32'(reqs.size()), 2);
    chk("t2 req_valid", 32'(imem_req_valid), 0);
    chk("t2 head pc", id_pc, 32'h100);
    id_ready = 1;
    run(10);
    chk("t2 delivered", 32'(got_pc.size() >= 6), 1);
    chk_stream("t2", 32'h100, 6);
    hold_reset(1);
    rst_n = 1;
    rand_ready = 1;
    rand_lat = 1;
    run(300);
    rand_ready = 0;
    rand_lat = 0;
    imem_req_ready = 1;
    run(20);
    n = got_pc.size();
    chk("t3 delivered", 32'(n >= 30), 1);
    chk_stream("t3", 32'h100, n);
    hold_reset(3);
    rst_n = 1;
    run(3);
    redirect_valid = 1;
    redirect_pc = 32'h2002;
    #2;
    chk("t4 req_valid at T", 32'(imem_req_valid), 0);
    cyc();
    redirect_valid = 0;
    #2;
    chk("t4 req_valid T+1", 32'(imem_req_valid), 1);
    chk("t4 req_addr T+1", imem_req_addr, 32'h2000);
    chk("t4 flushed T+1", 32'(id_valid), 0);
    run(15);
    chk_stream("t4", 32'h2000, 3);
    hold_reset(2);
    rst_n = 1;
    run(3);
    redirect_valid = 1;
    redirect_pc = 32'h400;
    #2;
    chk("t5 pop pc", id_pc, 32'h100);
    chk("t5 pop valid", 32'(id_valid), 1);
    cyc();
    redirect_pc = 32'h800;
    #2;
    chk("t5 flushed", 32'(id_valid), 0);
    chk("t5 req_valid", 32'(imem_req_valid), 0);
    cyc();
    redirect_valid = 0;
    #2;
    chk("t5 req_addr", imem_req_addr, 32'h800);
    run(12);
    chk_stream("t5a", 32'h100, 1);
    chk_stream("t5b", 32'h800, 3);
    id_ready = 0;
    hold_reset(1);
    rst_n = 1;
    redirect_valid = 1;
    redirect_pc = 32'hFFFF_FFF8;
    cyc();
    redirect_valid = 0;
    #2;
    chk("t6 req_addr", imem_req_addr, 32'hFFFF_FFF8);
    run(8);
    #2;
    chk("t6 full req_valid", 32'(imem_req_valid), 0);
    chk("t6 head", id_pc, 32'hFFFF_FFF8);
    imem_rsp_valid = 1;
    imem_rsp_data = 32'hDEAD_BEEF;
    cyc();
    #2;
    chk("t6 spurious head", id_pc, 32'hFFFF_FFF8);
    chk("t6 spurious instr", id_instr, word(32'hFFFF_FFF8));
    id_ready = 1;
    run(12);
    chk_stream("t6", 32'hFFFF_FFF8, 4);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
